// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared raster timing constants and types for the 640x480@60 Hz
//            VGA path. The timing generator and the per-pixel drawing blocks
//            all take their geometry from here.
// Contents : visible/porch/sync sizes, derived totals and sync spans,
//            counter widths, counter types and a span-test helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Horizontal geometry, in pixels
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  // Vertical geometry, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  // Derived totals: 800 pixels per line, 525 lines per frame
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Inclusive sync spans: hsync 656..751, vsync 490..491
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Counter widths
  localparam int CNT_W  = 10;  // covers 0..799 and 0..524
  localparam int FCNT_W = 4;   // frame divider and speed selector

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [FCNT_W-1:0] fcnt_t;

  // True when val lies in the inclusive range lo..hi
  function automatic logic in_span(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator. Divides the 100 MHz clock into a
//            25 MHz pixel strobe, sweeps the pixel column/line counters and
//            produces registered sync, blank, frame_end and a move strobe
//            issued once every speed+1 frames.
// Ports    : clk       in   system clock
//            rst       in   asynchronous, active-high reset
//            speed     in   [3:0] move strobe every speed+1 frames
//            pixpulse  out  one-clk strobe, every 4th clk
//            hcount    out  [9:0] pixel column
//            vcount    out  [9:0] line
//            hsync     out  active-low horizontal sync
//            vsync     out  active-low vertical sync
//            blank     out  high outside the visible area
//            frame_end out  high for the pixel period at (0,V_VISIBLE)
//            move      out  high for that same pixel period on selected frames
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                speed,
  output logic                      pixpulse,
  output logic [vga_pkg::CNT_W-1:0] hcount,
  output logic [vga_pkg::CNT_W-1:0] vcount,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      blank,
  output logic                      frame_end,
  output logic                      move
);

  import vga_pkg::*;

  // --------------------------------------------------------------------------
  // Geometry constants for this instance
  // --------------------------------------------------------------------------
  localparam int   c_H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int   c_V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam cnt_t c_H_LAST       = cnt_t'(c_H_TOTAL - 1);
  localparam cnt_t c_V_LAST       = cnt_t'(c_V_TOTAL - 1);
  localparam cnt_t c_H_VIS        = cnt_t'(H_VISIBLE);
  localparam cnt_t c_V_VIS        = cnt_t'(V_VISIBLE);
  localparam cnt_t c_H_SYNC_START = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t c_H_SYNC_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t c_V_SYNC_START = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t c_V_SYNC_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0] r_pdiv;
  cnt_t       r_hcount;
  cnt_t       r_vcount;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank;
  logic       r_frame_end;
  logic       r_move;
  fcnt_t      r_fcnt;
  fcnt_t      r_speed_q;

  cnt_t       w_hcount_next;
  cnt_t       w_vcount_next;
  logic       w_pixpulse;
  logic       w_at_wrap;
  logic       w_at_eval;
  logic       w_move_now;

  // --------------------------------------------------------------------------
  // Pixel clock divider. The strobe is a pure decode of the divider register,
  // so it is glitch-free relative to clk and is 0 straight out of reset.
  // --------------------------------------------------------------------------
  assign w_pixpulse = (r_pdiv == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pdiv <= 2'd0;
    end else begin
      r_pdiv <= r_pdiv + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Next raster position. Holds between pixel strobes; on a strobe it steps
  // the column and, at the end of a line, the line counter.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hcount_next = r_hcount;
    w_vcount_next = r_vcount;
    if (w_pixpulse) begin
      if (r_hcount == c_H_LAST) begin
        w_hcount_next = '0;
        w_vcount_next = (r_vcount == c_V_LAST) ? '0 : (r_vcount + cnt_t'(1));
      end else begin
        w_hcount_next = r_hcount + cnt_t'(1);
      end
    end
  end

  // Entering (0,0): only reachable by a wrap, never by holding after reset
  assign w_at_wrap  = w_pixpulse && (w_hcount_next == '0) && (w_vcount_next == '0);
  // Entering (0,V_VISIBLE): the once-per-frame divider evaluation point
  assign w_at_eval  = w_pixpulse && (w_hcount_next == '0) && (w_vcount_next == c_V_VIS);
  // >= rather than == so a speed drop below the running count still fires
  assign w_move_now = (r_fcnt >= r_speed_q);

  // --------------------------------------------------------------------------
  // Counters and raster flags. The flags are computed from the next position
  // so they are loaded on the same edge as the counters and always describe
  // the hcount/vcount currently on the outputs. Since the next position equals
  // the current one between strobes, frame_end naturally spans all 4 clks of
  // the pixel period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_blank     <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_hcount    <= w_hcount_next;
      r_vcount    <= w_vcount_next;
      r_hsync     <= !in_span(w_hcount_next, c_H_SYNC_START, c_H_SYNC_END);
      r_vsync     <= !in_span(w_vcount_next, c_V_SYNC_START, c_V_SYNC_END);
      r_blank     <= (w_hcount_next >= c_H_VIS) || (w_vcount_next >= c_V_VIS);
      r_frame_end <= (w_hcount_next == '0) && (w_vcount_next == c_V_VIS);
    end
  end

  // --------------------------------------------------------------------------
  // Frame divider. speed is sampled only at the frame wrap so a mid-frame
  // change cannot split a frame between two rates. move is decided once on
  // entering (0,V_VISIBLE) and dropped on the next pixel strobe, so it covers
  // exactly one pixel period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed_q <= '0;
      r_fcnt    <= '0;
      r_move    <= 1'b0;
    end else begin
      if (w_at_wrap) begin
        r_speed_q <= speed;
      end
      if (w_at_eval) begin
        r_move <= w_move_now;
        r_fcnt <= w_move_now ? '0 : (r_fcnt + fcnt_t'(1));
      end else if (w_pixpulse) begin
        r_move <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pixpulse  = w_pixpulse;
  assign hcount    = r_hcount;
  assign vcount    = r_vcount;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign blank     = r_blank;
  assign frame_end = r_frame_end;
  assign move      = r_move;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing. A full-size instance is
//            checked against hand-computed values over its first line; a
//            reduced-geometry instance is checked every clk against a model
//            that derives the raster position from the clk count since reset
//            and applies the frame-divider rule once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  // Reduced geometry: 24 pixels x 12 lines, so a frame is 1152 clk
  localparam int S_HV = 16, S_HFP = 2, S_HS = 4, S_HBP = 2;
  localparam int S_VV = 6,  S_VFP = 2, S_VS = 2, S_VBP = 2;
  localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME_PIX = S_HT * S_VT;
  localparam int S_FRAME_CLK = 4 * S_FRAME_PIX;
  localparam int S_HSS = S_HV + S_HFP, S_HSE = S_HV + S_HFP + S_HS - 1;
  localparam int S_VSS = S_VV + S_VFP, S_VSE = S_VV + S_VFP + S_VS - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] speed;
  bit         cmp_en = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reduced instance outputs
  logic       s_pix, s_hsync, s_vsync, s_blank, s_fe, s_move;
  logic [9:0] s_hcount, s_vcount;
  // Full-size instance outputs
  logic       f_pix, f_hsync, f_vsync, f_blank, f_fe, f_move;
  logic [9:0] f_hcount, f_vcount;

  always #5 clk = ~clk;

  vga_timing #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_dut (
    .clk(clk), .rst(rst), .speed(speed),
    .pixpulse(s_pix), .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank),
    .frame_end(s_fe), .move(s_move)
  );

  vga_timing u_full (
    .clk(clk), .rst(rst), .speed(4'd0),
    .pixpulse(f_pix), .hcount(f_hcount), .vcount(f_vcount),
    .hsync(f_hsync), .vsync(f_vsync), .blank(f_blank),
    .frame_end(f_fe), .move(f_move)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. After n clk edges out of reset the design has completed
  // n/4 pixels, so the position is plain division of that pixel count.
  // The divider keeps one decision per frame: sampled speed at each wrap and
  // an evaluation on entering (0,S_VV).
  // --------------------------------------------------------------------------
  int m_n    = 0;
  int m_fcnt = 0;
  int m_spq  = 0;
  bit m_mv   = 1'b0;

  function automatic int ph(input int n);
    return (n / 4) % S_HT;
  endfunction
  function automatic int pv(input int n);
    return ((n / 4) / S_HT) % S_VT;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n    <= 0;
      m_fcnt <= 0;
      m_spq  <= 0;
      m_mv   <= 1'b0;
    end else begin
      m_n <= m_n + 1;
      if ((m_n + 1) % 4 == 0) begin
        if (ph(m_n + 1) == 0 && pv(m_n + 1) == 0)
          m_spq <= int'(speed);
        if (ph(m_n + 1) == 0 && pv(m_n + 1) == S_VV) begin
          if (m_fcnt >= m_spq) begin
            m_mv   <= 1'b1;
            m_fcnt <= 0;
          end else begin
            m_mv   <= 1'b0;
            m_fcnt <= m_fcnt + 1;
          end
        end
      end
    end
  end

  // Per-clk comparison of the reduced instance, sampled on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pixpulse",  s_pix,    32'((m_n % 4) == 3));
      chk("hcount",    s_hcount, 32'(ph(m_n)));
      chk("vcount",    s_vcount, 32'(pv(m_n)));
      chk("hsync",     s_hsync,  32'(!(ph(m_n) >= S_HSS && ph(m_n) <= S_HSE)));
      chk("vsync",     s_vsync,  32'(!(pv(m_n) >= S_VSS && pv(m_n) <= S_VSE)));
      chk("blank",     s_blank,  32'(ph(m_n) >= S_HV || pv(m_n) >= S_VV));
      chk("frame_end", s_fe,     32'(ph(m_n) == 0 && pv(m_n) == S_VV));
      chk("move",      s_move,   32'(ph(m_n) == 0 && pv(m_n) == S_VV && m_mv));
    end
  end

  task automatic do_reset(input logic [3:0] spd);
    @(posedge clk);
    #3;
    rst   = 1'b1;
    speed = spd;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Runs whole frames from reset release, recording in which frames move
  // was seen and how wide the move/frame_end strobes were.
  task automatic run_count(input int nframes, input int chg_at, input logic [3:0] chg_val,
                           input bit rnd, output logic [31:0] mask, output int mv_clk,
                           output int mv_pix, output int fe_clk);
    mask   = '0;
    mv_clk = 0;
    mv_pix = 0;
    fe_clk = 0;
    for (int k = 1; k <= nframes * S_FRAME_CLK; k++) begin
      @(posedge clk);
      #1;
      if (s_move) begin
        mask[(k / 4) / S_FRAME_PIX] = 1'b1;
        mv_clk++;
        if (s_pix) mv_pix++;
      end
      if (s_fe) fe_clk++;
      if (chg_at == k) speed = chg_val;
      if (rnd && $urandom_range(0, 299) == 0) speed = 4'($urandom_range(0, 5));
    end
  endtask

  initial begin
    logic [19:0] pixpat;
    logic [31:0] mask;
    int mv_clk, mv_pix, fe_clk;
    int hs_low_pix, first_hs, last_hs, first_blank, bad;
    bit found;

    rst   = 1'b1;
    speed = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Reset values of the full-size instance
    chk("rst_pixpulse",  f_pix,    0);
    chk("rst_hcount",    f_hcount, 0);
    chk("rst_vcount",    f_vcount, 0);
    chk("rst_hsync",     f_hsync,  1);
    chk("rst_vsync",     f_vsync,  1);
    chk("rst_blank",     f_blank,  0);
    chk("rst_frame_end", f_fe,     0);
    chk("rst_move",      f_move,   0);

    // ---- First line of the full-size instance -----------------------------
    @(posedge clk);
    #3;
    rst         = 1'b0;
    pixpat      = '0;
    hs_low_pix  = 0;
    first_hs    = -1;
    last_hs     = -1;
    first_blank = -1;
    bad         = 0;
    for (int k = 1; k <= 3200; k++) begin
      @(posedge clk);
      #1;
      if (k <= 20) begin
        pixpat[k-1] = f_pix;
        if (!f_hsync || f_blank) bad++;
      end
      if (k == 3)  chk("hcount_edge3", f_hcount, 0);
      if (k == 4)  chk("hcount_edge4", f_hcount, 1);
      if (k == 20) chk("hcount_edge20", f_hcount, 5);
      if (f_pix && !f_hsync) hs_low_pix++;
      if (!f_hsync) begin
        if (first_hs < 0) first_hs = int'(f_hcount);
        last_hs = int'(f_hcount);
      end
      if (f_blank && first_blank < 0 && f_vcount == 10'd0) first_blank = int'(f_hcount);
      if (!f_vsync || f_fe || f_move) bad++;
      if (k == 3199) begin
        chk("hcount_line_end", f_hcount, 799);
        chk("vcount_line_end", f_vcount, 0);
      end
      if (k == 3200) begin
        chk("hcount_wrap", f_hcount, 0);
        chk("vcount_wrap", f_vcount, 1);
      end
    end
    chk("pixpulse_pattern", 32'(pixpat), 32'h44444);
    chk("hsync_low_pixels", hs_low_pix, 96);
    chk("hsync_first_col",  first_hs, 656);
    chk("hsync_last_col",   last_hs, 751);
    chk("blank_first_col",  first_blank, 640);
    chk("line0_stray_flags", bad, 0);

    // ---- speed=0: move on every frame, one pixel period wide --------------
    do_reset(4'd0);
    run_count(3, 0, 4'd0, 1'b0, mask, mv_clk, mv_pix, fe_clk);
    chk("spd0_move_frames", mask, 32'b111);
    chk("spd0_move_clks",   mv_clk, 12);
    chk("spd0_move_pix",    mv_pix, 3);
    chk("spd0_fe_clks",     fe_clk, 12);

    // ---- speed=2 held: move on frames 0, 3, 6 -----------------------------
    do_reset(4'd2);
    run_count(7, 0, 4'd0, 1'b0, mask, mv_clk, mv_pix, fe_clk);
    chk("spd2_move_frames", mask, 32'b1001001);
    chk("spd2_move_clks",   mv_clk, 12);

    // ---- speed 2->0 in frame 1 after its evaluation (fcnt=1) --------------
    do_reset(4'd2);
    run_count(5, S_FRAME_CLK + 4 * (S_VV + 1) * S_HT + 4, 4'd0, 1'b0,
              mask, mv_clk, mv_pix, fe_clk);
    chk("spd_drop_move_frames", mask, 32'b11101);

    // ---- randomized speed changes, checked by the per-clk model -----------
    do_reset(4'($urandom_range(0, 5)));
    run_count(20, 0, 4'd0, 1'b1, mask, mv_clk, mv_pix, fe_clk);

    // ---- asynchronous reset mid-frame at (10,4) ---------------------------
    found = 1'b0;
    for (int k = 0; k < 2 * S_FRAME_CLK && !found; k++) begin
      @(posedge clk);
      #1;
      if (s_hcount == 10'd10 && s_vcount == 10'd4) found = 1'b1;
    end
    chk("reach_reset_point", 32'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pixpulse",  s_pix,    0);
    chk("async_hcount",    s_hcount, 0);
    chk("async_vcount",    s_vcount, 0);
    chk("async_hsync",     s_hsync,  1);
    chk("async_vsync",     s_vsync,  1);
    chk("async_blank",     s_blank,  0);
    chk("async_frame_end", s_fe,     0);
    chk("async_move",      s_move,   0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    run_count(1, 0, 4'd0, 1'b0, mask, mv_clk, mv_pix, fe_clk);
    chk("post_rst_move_frames", mask, 32'b1);
    chk("post_rst_move_clks",   mv_clk, 4);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
